// File: rtl/recirc_buffered.sv
// Recirculating lane buffer: forwards words downstream when the consumer is
// idle, otherwise echoes them back on the recirculation path and parks them
// in a small FIFO that is drained ahead of new traffic once forwarding resumes.
module recirc_buffered #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_f,
  input  logic                     reset,
  input  logic                     IDLE_OUT,
  input  logic [LANES*DW-1:0]      data_in,
  input  logic [LANES-1:0]         valid_in,
  output logic [LANES*DW-1:0]      data_rf,
  output logic [LANES-1:0]         valid_rf,
  output logic [LANES*DW-1:0]      data_rp,
  output logic [LANES-1:0]         valid_rp,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE_COUNT  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RECIRC = 2'd0,
    DRAIN  = 2'd1,
    PASS   = 2'd2
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LANES*DW-1:0]  mem_data  [DEPTH];
  logic [LANES-1:0]     mem_valid [DEPTH];

  logic is_word;
  logic fifo_empty;
  logic fifo_full;
  logic mode_recirc;
  logic mode_drain;
  logic do_push;
  logic do_pop;

  assign state = state_q;

  // Pick this cycle's routing mode and decide whether the FIFO is pushed/popped.
  // A push while draining always fits because the pop frees a slot in the same cycle.
  always_comb begin
    is_word     = |valid_in;
    fifo_empty  = (fifo_count == '0);
    fifo_full   = (fifo_count == FULL_COUNT);
    mode_recirc = !IDLE_OUT;
    mode_drain  = IDLE_OUT && !fifo_empty;
    do_pop      = mode_drain;
    do_push     = is_word && (mode_drain || (mode_recirc && !fifo_full));
  end

  // FIFO storage keeps the valid vector alongside the data so partial words survive.
  always_ff @(posedge clk_f) begin
    if (do_push) begin
      mem_data[wr_ptr]  <= data_in;
      mem_valid[wr_ptr] <= valid_in;
    end
  end

  // Pointers, occupancy, sticky overflow, FSM state and registered output paths.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      state_q    <= RECIRC;
      data_rf    <= '0;
      valid_rf   <= '0;
      data_rp    <= '0;
      valid_rp   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (do_pop && !do_push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (mode_recirc && is_word && fifo_full) begin
        overflow <= 1'b1;
      end

      data_rf  <= '0;
      valid_rf <= '0;
      data_rp  <= '0;
      valid_rp <= '0;

      if (mode_recirc) begin
        state_q <= RECIRC;
        if (is_word) begin
          data_rp  <= data_in;
          valid_rp <= valid_in;
        end
      end else if (mode_drain) begin
        data_rf  <= mem_data[rd_ptr];
        valid_rf <= mem_valid[rd_ptr];
        state_q  <= (fifo_count == ONE_COUNT && !is_word) ? PASS : DRAIN;
      end else begin
        state_q <= PASS;
        if (is_word) begin
          data_rf  <= data_in;
          valid_rf <= valid_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_recirc_buffered.sv
// Self-checking bench for recirc_buffered: a directed vector table, a few
// multi-cycle corner sequences, and randomized traffic against a queue-based model.
module tb_recirc_buffered;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic        clk_f;
  logic        reset;
  logic        IDLE_OUT;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [31:0] data_rf;
  logic [3:0]  valid_rf;
  logic [31:0] data_rp;
  logic [3:0]  valid_rp;
  logic [1:0]  state;
  logic [2:0]  fifo_count;
  logic        overflow;

  int vec_count;
  int err_count;

  recirc_buffered #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .IDLE_OUT   (IDLE_OUT),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_rf    (data_rf),
    .valid_rf   (valid_rf),
    .data_rp    (data_rp),
    .valid_rp   (valid_rp),
    .state      (state),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  // Behavioural model: a queue of parked words plus the expected registered outputs.
  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
  } word_t;

  word_t       m_q[$];
  logic        m_ovf;
  logic [1:0]  m_st;
  logic [3:0]  m_vrf;
  logic [31:0] m_drf;
  logic [3:0]  m_vrp;
  logic [31:0] m_drp;

  typedef struct {
    logic        idle;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  e_vrf;
    logic [31:0] e_drf;
    logic [3:0]  e_vrp;
    logic [31:0] e_drp;
    logic [1:0]  e_st;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic modelReset();
    m_q.delete();
    m_ovf = 1'b0;
    m_st  = 2'd0;
    m_vrf = '0; m_drf = '0; m_vrp = '0; m_drp = '0;
  endtask

  task automatic modelStep(input logic idle, input logic [3:0] v, input logic [31:0] d);
    word_t w;
    word_t head;
    w.v = v;
    w.d = d;
    m_vrf = '0; m_drf = '0; m_vrp = '0; m_drp = '0;
    if (!idle) begin
      if (v != 0) begin
        m_vrp = v;
        m_drp = d;
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1'b1;
      end
      m_st = 2'd0;
    end else if (m_q.size() > 0) begin
      head  = m_q.pop_front();
      m_vrf = head.v;
      m_drf = head.d;
      if (v != 0) m_q.push_back(w);
      m_st = (m_q.size() == 0) ? 2'd2 : 2'd1;
    end else begin
      if (v != 0) begin
        m_vrf = v;
        m_drf = d;
      end
      m_st = 2'd2;
    end
  endtask

  task automatic applyStimulus(input logic idle, input logic [3:0] v, input logic [31:0] d);
    IDLE_OUT = idle;
    valid_in = v;
    data_in  = d;
    modelStep(idle, v, d);
    @(posedge clk_f);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [3:0] e_vrf, input logic [31:0] e_drf,
                             input logic [3:0] e_vrp, input logic [31:0] e_drp,
                             input logic [1:0] e_st, input logic [2:0] e_cnt,
                             input logic e_ovf);
    vec_count++;
    if (valid_rf !== e_vrf || data_rf !== e_drf || valid_rp !== e_vrp ||
        data_rp !== e_drp || state !== e_st || fifo_count !== e_cnt ||
        overflow !== e_ovf) begin
      err_count++;
      $display("[TB] FAIL %s: got rf=%h/%h rp=%h/%h st=%0d cnt=%0d ovf=%0d, expected rf=%h/%h rp=%h/%h st=%0d cnt=%0d ovf=%0d",
               name, valid_rf, data_rf, valid_rp, data_rp, state, fifo_count, overflow,
               e_vrf, e_drf, e_vrp, e_drp, e_st, e_cnt, e_ovf);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_vrf, m_drf, m_vrp, m_drp, m_st, 3'(m_q.size()), m_ovf);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    IDLE_OUT = 1'b0;
    valid_in = '0;
    data_in  = '0;
    modelReset();
    repeat (2) @(posedge clk_f);
    @(negedge clk_f);
    reset = 1'b0;
    #1;
  endtask

  // Main test sequence.
  initial begin
    vec_count = 0;
    err_count = 0;
    reset     = 1'b0;
    IDLE_OUT  = 1'b0;
    valid_in  = '0;
    data_in   = '0;

    // Directed table: pass-through, recirculate/drain, overflow, full drain with push.
    tbl[0]  = '{1'b1, 4'hF, 32'h44332211, 4'hF, 32'h44332211, 4'h0, 32'h0, 2'd2, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 32'h000000AA, 4'h0, 32'h0, 4'h1, 32'h000000AA, 2'd0, 3'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'h2, 32'h0000BB00, 4'h0, 32'h0, 4'h2, 32'h0000BB00, 2'd0, 3'd2, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0,        4'h1, 32'h000000AA, 4'h0, 32'h0, 2'd1, 3'd1, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 32'h0,        4'h2, 32'h0000BB00, 4'h0, 32'h0, 2'd2, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 32'h0,        4'h0, 32'h0, 4'h0, 32'h0, 2'd2, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'h1, 32'h00000011, 4'h0, 32'h0, 4'h1, 32'h00000011, 2'd0, 3'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'h3, 32'h00002222, 4'h0, 32'h0, 4'h3, 32'h00002222, 2'd0, 3'd2, 1'b0};
    tbl[8]  = '{1'b0, 4'h7, 32'h00333333, 4'h0, 32'h0, 4'h7, 32'h00333333, 2'd0, 3'd3, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 32'h44444444, 4'h0, 32'h0, 4'hF, 32'h44444444, 2'd0, 3'd4, 1'b0};
    tbl[10] = '{1'b0, 4'h8, 32'h55000000, 4'h0, 32'h0, 4'h8, 32'h55000000, 2'd0, 3'd4, 1'b1};
    tbl[11] = '{1'b1, 4'h5, 32'h00660066, 4'h1, 32'h00000011, 4'h0, 32'h0, 2'd1, 3'd4, 1'b1};
    tbl[12] = '{1'b1, 4'hA, 32'h77007700, 4'h3, 32'h00002222, 4'h0, 32'h0, 2'd1, 3'd4, 1'b1};
    tbl[13] = '{1'b1, 4'h0, 32'h0,        4'h7, 32'h00333333, 4'h0, 32'h0, 2'd1, 3'd3, 1'b1};
    tbl[14] = '{1'b1, 4'h0, 32'h0,        4'hF, 32'h44444444, 4'h0, 32'h0, 2'd1, 3'd2, 1'b1};
    tbl[15] = '{1'b1, 4'h0, 32'h0,        4'h5, 32'h00660066, 4'h0, 32'h0, 2'd1, 3'd1, 1'b1};
    tbl[16] = '{1'b1, 4'h0, 32'h0,        4'hA, 32'h77007700, 4'h0, 32'h0, 2'd2, 3'd0, 1'b1};
    tbl[17] = '{1'b1, 4'h0, 32'hDEADBEEF, 4'h0, 32'h0, 4'h0, 32'h0, 2'd2, 3'd0, 1'b1};

    doReset();
    checkOutput("reset_state", 4'h0, 32'h0, 4'h0, 32'h0, 2'd0, 3'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].idle, tbl[i].v, tbl[i].d);
      checkOutput($sformatf("table_%0d", i), tbl[i].e_vrf, tbl[i].e_drf,
                  tbl[i].e_vrp, tbl[i].e_drp, tbl[i].e_st, tbl[i].e_cnt, tbl[i].e_ovf);
    end

    // Drain interrupted by one recirculate cycle carrying word C.
    doReset();
    applyStimulus(1'b0, 4'h1, 32'h000000A1); checkModel("int_push1");
    applyStimulus(1'b0, 4'h2, 32'h0000A200); checkModel("int_push2");
    applyStimulus(1'b0, 4'h4, 32'h00A30000); checkModel("int_push3");
    applyStimulus(1'b1, 4'h0, 32'h0);        checkModel("int_drain1");
    applyStimulus(1'b0, 4'hC, 32'hCC0C0000);
    checkOutput("int_recirc_c", 4'h0, 32'h0, 4'hC, 32'hCC0C0000, 2'd0, 3'd3, 1'b0);
    applyStimulus(1'b1, 4'h0, 32'h0);
    checkOutput("int_old1", 4'h2, 32'h0000A200, 4'h0, 32'h0, 2'd1, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'h0, 32'h0);
    checkOutput("int_old2", 4'h4, 32'h00A30000, 4'h0, 32'h0, 2'd1, 3'd1, 1'b0);
    applyStimulus(1'b1, 4'h0, 32'h0);
    checkOutput("int_c", 4'hC, 32'hCC0C0000, 4'h0, 32'h0, 2'd2, 3'd0, 1'b0);

    // Asynchronous reset in the middle of a drain with three entries left.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'hF, 32'h10101010 * (i + 1));
    end
    applyStimulus(1'b1, 4'h0, 32'h0);
    checkOutput("pre_reset_drain", 4'hF, 32'h10101010, 4'h0, 32'h0, 2'd1, 3'd3, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 4'h0, 32'h0, 4'h0, 32'h0, 2'd0, 3'd0, 1'b0);
    modelReset();
    @(negedge clk_f);
    reset = 1'b0;
    #1;
    applyStimulus(1'b1, 4'h0, 32'h0);
    checkOutput("post_reset_pass", 4'h0, 32'h0, 4'h0, 32'h0, 2'd2, 3'd0, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic       r_idle;
      logic [3:0] r_v;
      r_idle = ($urandom_range(0, 99) < 55);
      r_v    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      applyStimulus(r_idle, r_v, $urandom);
      checkModel($sformatf("random_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
